pipe_ctrl: RTL and testbench

//  Pipeline controller for the integer datapath (D->X->M->W).

---
 rtl/proc_pkg.sv | 31 +++
 rtl/pipe_hazard_cmp.sv | 40 ++++
 rtl/pipe_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the integer pipeline controller: forwarding selects, controller
// states and the per-stage bookkeeping record.
package proc_pkg;
    localparam int unsigned RD_W_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        PCTL_RUN     = 1'b0,
        PCTL_MC_WAIT = 1'b1
    } pctl_state_e;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                we;
        logic                load;
        logic                mc;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

    // Only a valid stage that really writes a non-zero rd can be a RAW producer.
    function automatic logic stage_writes(stage_info_t s);
        return s.valid && s.we && (s.rd != '0);
    endfunction
endpackage

// File: rtl/pipe_hazard_cmp.sv
// Compares one D source register against the X/M/W destinations and reports the
// forwarding source plus load-use and plain RAW hits.
module pipe_hazard_cmp
    import proc_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] x_rd_i,
    input  logic              x_wr_i,
    input  logic              x_load_i,
    input  logic [REG_AW-1:0] m_rd_i,
    input  logic              m_wr_i,
    input  logic [REG_AW-1:0] w_rd_i,
    input  logic              w_wr_i,
    output fwd_sel_e          sel_o,
    output logic              load_hit_o,
    output logic              raw_hit_o
);
    logic x_hit;
    logic m_hit;
    logic w_hit;

    always_comb begin
        x_hit = x_wr_i && (rs_i == x_rd_i);
        m_hit = m_wr_i && (rs_i == m_rd_i);
        w_hit = w_wr_i && (rs_i == w_rd_i);

        // X is the youngest producer, so it wins over M.
        sel_o = FWD_RF;
        if (x_hit) begin
            sel_o = FWD_M;
        end else if (m_hit) begin
            sel_o = FWD_W;
        end

        load_hit_o = x_hit && x_load_i;
        raw_hit_o  = x_hit || m_hit || w_hit;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the D->X->M->W integer datapath: stage tracking,
// forwarding selects, load-use/RAW stalls, branch flush and mul/div sequencing.
//   state        | meaning
//   PCTL_RUN     | normal issue; hazards and taken branches handled here
//   PCTL_MC_WAIT | mul/div op parked in X until mc_done_i
module pipe_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_valid_i,
    input  logic [REG_AW-1:0] d_rs1_i,
    input  logic [REG_AW-1:0] d_rs2_i,
    input  logic [REG_AW-1:0] d_rd_i,
    input  logic              d_we_i,
    input  logic              d_is_load_i,
    input  logic              d_is_mc_i,
    input  logic              x_br_taken_i,
    input  logic              mc_done_i,
    output logic              fd_stall_o,
    output logic              fd_flush_o,
    output logic              x_bubble_o,
    output logic [1:0]        fwd_op1_sel_o,
    output logic [1:0]        fwd_op2_sel_o,
    output logic              mc_start_o,
    output logic              mc_err_o,
    output logic              x_valid_o,
    output logic              m_valid_o,
    output logic              w_valid_o,
    output logic              w_we_o,
    output logic [REG_AW-1:0] w_rd_o
);
    localparam int unsigned CNT_W = $clog2(MC_TIMEOUT + 1);

    pctl_state_e      state_q, state_d;
    stage_info_t      x_q, x_d, m_q, m_d, w_q, w_d;
    fwd_sel_e         op1_sel_q, op1_sel_d, op2_sel_q, op2_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    stage_info_t       d_info;
    fwd_sel_e          sel1, sel2;
    logic              load_hit1, load_hit2, raw_hit1, raw_hit2;
    logic              x_wr, m_wr, w_wr;
    logic [REG_AW-1:0] x_rd, m_rd, w_rd;
    logic              x_hold, hazard;
    logic              unused_stage_bits;

    assign x_wr = stage_writes(x_q);
    assign m_wr = stage_writes(m_q);
    assign w_wr = stage_writes(w_q);
    assign x_rd = x_q.rd[REG_AW-1:0];
    assign m_rd = m_q.rd[REG_AW-1:0];
    assign w_rd = w_q.rd[REG_AW-1:0];
    assign unused_stage_bits = ^{x_q.rd, m_q.rd, w_q.rd, m_q.load, m_q.mc, w_q.load, w_q.mc};

    pipe_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
        .rs_i(d_rs1_i), .x_rd_i(x_rd), .x_wr_i(x_wr), .x_load_i(x_q.load),
        .m_rd_i(m_rd), .m_wr_i(m_wr), .w_rd_i(w_rd), .w_wr_i(w_wr),
        .sel_o(sel1), .load_hit_o(load_hit1), .raw_hit_o(raw_hit1)
    );

    pipe_hazard_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
        .rs_i(d_rs2_i), .x_rd_i(x_rd), .x_wr_i(x_wr), .x_load_i(x_q.load),
        .m_rd_i(m_rd), .m_wr_i(m_wr), .w_rd_i(w_rd), .w_wr_i(w_wr),
        .sel_o(sel2), .load_hit_o(load_hit2), .raw_hit_o(raw_hit2)
    );

    always_comb begin
        d_info       = STAGE_BUBBLE;
        d_info.valid = d_valid_i;
        d_info.rd    = RD_W_MAX'(d_rd_i);
        d_info.we    = d_we_i;
        d_info.load  = d_is_load_i;
        d_info.mc    = d_is_mc_i;
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        m_d        = x_q;
        w_d        = m_q;
        op1_sel_d  = op1_sel_q;
        op2_sel_d  = op2_sel_q;
        cnt_d      = '0;
        err_d      = err_q;
        fd_stall_o = 1'b0;
        fd_flush_o = 1'b0;
        x_bubble_o = 1'b0;
        mc_start_o = 1'b0;
        x_hold     = 1'b0;

        hazard = d_valid_i && (load_hit1 || load_hit2 ||
                               (!FWD_EN && (raw_hit1 || raw_hit2)));

        case (state_q)
            PCTL_RUN: begin
                if (x_q.valid && x_q.mc) begin
                    mc_start_o = 1'b1;
                    x_hold     = 1'b1;
                    state_d    = PCTL_MC_WAIT;
                end else if (x_br_taken_i && x_q.valid) begin
                    fd_flush_o = 1'b1;
                    x_bubble_o = 1'b1;
                end else if (hazard) begin
                    fd_stall_o = 1'b1;
                    x_bubble_o = 1'b1;
                end
            end
            PCTL_MC_WAIT: begin
                if (mc_done_i) begin
                    state_d = PCTL_RUN;
                    if (hazard) begin
                        fd_stall_o = 1'b1;
                        x_bubble_o = 1'b1;
                    end
                end else begin
                    x_hold = 1'b1;
                    cnt_d  = (cnt_q == CNT_W'(MC_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
                    // Set one wait cycle early so the flag is visible in wait cycle MC_TIMEOUT.
                    if (cnt_q >= CNT_W'(MC_TIMEOUT - 2)) begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        if (x_hold) begin
            fd_stall_o = 1'b1;
            m_d        = STAGE_BUBBLE;
        end else if (x_bubble_o || !d_valid_i) begin
            x_d = STAGE_BUBBLE;
        end else begin
            x_d = d_info;
        end

        if (!fd_stall_o) begin
            op1_sel_d = (d_valid_i && FWD_EN) ? sel1 : FWD_RF;
            op2_sel_d = (d_valid_i && FWD_EN) ? sel2 : FWD_RF;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= PCTL_RUN;
            x_q       <= STAGE_BUBBLE;
            m_q       <= STAGE_BUBBLE;
            w_q       <= STAGE_BUBBLE;
            op1_sel_q <= FWD_RF;
            op2_sel_q <= FWD_RF;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            m_q       <= m_d;
            w_q       <= w_d;
            op1_sel_q <= op1_sel_d;
            op2_sel_q <= op2_sel_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign fwd_op1_sel_o = op1_sel_q;
    assign fwd_op2_sel_o = op2_sel_q;
    assign mc_err_o      = err_q;
    assign x_valid_o     = x_q.valid;
    assign m_valid_o     = m_q.valid;
    assign w_valid_o     = w_q.valid;
    assign w_we_o        = w_q.valid && w_q.we;
    assign w_rd_o        = w_rd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected outputs tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_pipe_ctrl;
    localparam int unsigned AW = 5;

    localparam int S_STALL = 0, S_FLUSH = 1, S_BUB = 2, S_OP1 = 3, S_OP2 = 4,
                   S_START = 5, S_ERR = 6, S_XV = 7, S_MV = 8, S_WV = 9,
                   S_WWE = 10, S_WRD = 11, S_NF_STALL = 12, S_NF_BUB = 13,
                   S_NF_OP1 = 14, S_NF_XV = 15;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          d_valid_i, d_we_i, d_is_load_i, d_is_mc_i, x_br_taken_i, mc_done_i;
    logic [AW-1:0] d_rs1_i, d_rs2_i, d_rd_i;

    logic          fd_stall_o, fd_flush_o, x_bubble_o, mc_start_o, mc_err_o;
    logic [1:0]    fwd_op1_sel_o, fwd_op2_sel_o;
    logic          x_valid_o, m_valid_o, w_valid_o, w_we_o;
    logic [AW-1:0] w_rd_o;

    logic          nf_fd_stall_o, nf_fd_flush_o, nf_x_bubble_o, nf_mc_start_o, nf_mc_err_o;
    logic [1:0]    nf_fwd_op1_sel_o, nf_fwd_op2_sel_o;
    logic          nf_x_valid_o, nf_m_valid_o, nf_w_valid_o, nf_w_we_o;
    logic [AW-1:0] nf_w_rd_o;

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    due_q[$];
    int    sig_q[$];
    int    val_q[$];
    string tag_q[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    pipe_ctrl #(.REG_AW(AW), .FWD_EN(1'b1), .MC_TIMEOUT(4)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i),
        .d_rs2_i(d_rs2_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i), .d_is_load_i(d_is_load_i),
        .d_is_mc_i(d_is_mc_i), .x_br_taken_i(x_br_taken_i), .mc_done_i(mc_done_i),
        .fd_stall_o(fd_stall_o), .fd_flush_o(fd_flush_o), .x_bubble_o(x_bubble_o),
        .fwd_op1_sel_o(fwd_op1_sel_o), .fwd_op2_sel_o(fwd_op2_sel_o),
        .mc_start_o(mc_start_o), .mc_err_o(mc_err_o), .x_valid_o(x_valid_o),
        .m_valid_o(m_valid_o), .w_valid_o(w_valid_o), .w_we_o(w_we_o), .w_rd_o(w_rd_o)
    );

    pipe_ctrl #(.REG_AW(AW), .FWD_EN(1'b0), .MC_TIMEOUT(64)) u_nf (
        .clk_i(clk_i), .rst_i(rst_i), .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i),
        .d_rs2_i(d_rs2_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i), .d_is_load_i(d_is_load_i),
        .d_is_mc_i(d_is_mc_i), .x_br_taken_i(x_br_taken_i), .mc_done_i(mc_done_i),
        .fd_stall_o(nf_fd_stall_o), .fd_flush_o(nf_fd_flush_o), .x_bubble_o(nf_x_bubble_o),
        .fwd_op1_sel_o(nf_fwd_op1_sel_o), .fwd_op2_sel_o(nf_fwd_op2_sel_o),
        .mc_start_o(nf_mc_start_o), .mc_err_o(nf_mc_err_o), .x_valid_o(nf_x_valid_o),
        .m_valid_o(nf_m_valid_o), .w_valid_o(nf_w_valid_o), .w_we_o(nf_w_we_o),
        .w_rd_o(nf_w_rd_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] get_sig(input int id);
        case (id)
            S_STALL:    return 32'(fd_stall_o);
            S_FLUSH:    return 32'(fd_flush_o);
            S_BUB:      return 32'(x_bubble_o);
            S_OP1:      return 32'(fwd_op1_sel_o);
            S_OP2:      return 32'(fwd_op2_sel_o);
            S_START:    return 32'(mc_start_o);
            S_ERR:      return 32'(mc_err_o);
            S_XV:       return 32'(x_valid_o);
            S_MV:       return 32'(m_valid_o);
            S_WV:       return 32'(w_valid_o);
            S_WWE:      return 32'(w_we_o);
            S_WRD:      return 32'(w_rd_o);
            S_NF_STALL: return 32'(nf_fd_stall_o);
            S_NF_BUB:   return 32'(nf_x_bubble_o);
            S_NF_OP1:   return 32'(nf_fwd_op1_sel_o);
            S_NF_XV:    return 32'(nf_x_valid_o);
            default:    return 'x;
        endcase
    endfunction

    task automatic expect_at(input int dly, input int sig, input int val, input string tag);
        due_q.push_back(cyc + dly);
        sig_q.push_back(sig);
        val_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk_i) begin : sb_mon
        int    n, d, s, v;
        string t;
        n = due_q.size();
        for (int i = 0; i < n; i++) begin
            d = due_q.pop_front();
            s = sig_q.pop_front();
            v = val_q.pop_front();
            t = tag_q.pop_front();
            if (d == cyc) begin
                check_val(t, get_sig(s), 32'(v));
            end else begin
                due_q.push_back(d);
                sig_q.push_back(s);
                val_q.push_back(v);
                tag_q.push_back(t);
            end
        end
    end

    task automatic drv(input logic v, input int rs1, input int rs2, input int rd,
                       input logic we, input logic ld, input logic mc);
        d_valid_i   = v;
        d_rs1_i     = AW'(rs1);
        d_rs2_i     = AW'(rs2);
        d_rd_i      = AW'(rd);
        d_we_i      = we;
        d_is_load_i = ld;
        d_is_mc_i   = mc;
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        x_br_taken_i = 1'b0;
        mc_done_i    = 1'b0;
    endtask

    task automatic drain();
        repeat (4) begin
            idle();
            nxt();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        expect_at(0, S_STALL, 0, "rst_stall");
        expect_at(0, S_FLUSH, 0, "rst_flush");
        expect_at(0, S_BUB,   0, "rst_bubble");
        expect_at(0, S_OP1,   0, "rst_op1");
        expect_at(0, S_OP2,   0, "rst_op2");
        expect_at(0, S_START, 0, "rst_start");
        expect_at(0, S_ERR,   0, "rst_err");
        expect_at(0, S_XV,    0, "rst_xv");
        expect_at(0, S_MV,    0, "rst_mv");
        expect_at(0, S_WV,    0, "rst_wv");
        expect_at(0, S_WWE,   0, "rst_wwe");
        expect_at(0, S_WRD,   0, "rst_wrd");
        nxt();
        rst_i = 1'b0;
        drain();

        // ALU -> ALU back to back: forward from M, no stall
        drv(1, 0, 0, 1, 1, 0, 0); nxt();
        drv(1, 1, 2, 3, 1, 0, 0);
        expect_at(0, S_STALL, 0, "t1_stall");
        expect_at(0, S_BUB,   0, "t1_bubble");
        expect_at(1, S_OP1,   1, "t1_op1");
        expect_at(1, S_OP2,   0, "t1_op2");
        expect_at(1, S_XV,    1, "t1_xv");
        nxt();
        idle();
        expect_at(1, S_WWE, 1, "t1_wwe");
        expect_at(1, S_WRD, 1, "t1_wrd");
        nxt();
        drain();

        // producer two ahead forwards from W; two producers -> X wins
        drv(1, 0, 0, 8, 1, 0, 0); nxt();
        idle(); nxt();
        drv(1, 8, 0, 2, 1, 0, 0);
        expect_at(1, S_OP1, 2, "fwd_m_op1");
        nxt();
        drv(1, 0, 0, 9, 1, 0, 0); nxt();
        drv(1, 0, 0, 9, 1, 0, 0); nxt();
        drv(1, 9, 9, 2, 1, 0, 0);
        expect_at(1, S_OP1, 1, "fwd_prio_op1");
        expect_at(1, S_OP2, 1, "fwd_prio_op2");
        nxt();
        drain();

        // load-use: one stall + bubble, then W forwarding
        drv(1, 0, 0, 5, 1, 1, 0); nxt();
        drv(1, 6, 5, 7, 1, 0, 0);
        expect_at(0, S_STALL, 1, "t2_stall");
        expect_at(0, S_BUB,   1, "t2_bubble");
        expect_at(1, S_XV,    0, "t2_x_bubble");
        expect_at(1, S_MV,    1, "t2_load_in_m");
        nxt();
        expect_at(0, S_STALL, 0, "t2_stall_released");
        expect_at(1, S_OP2,   2, "t2_op2");
        expect_at(1, S_OP1,   0, "t2_op1");
        expect_at(1, S_XV,    1, "t2_consumer_in_x");
        nxt();
        drain();

        // x0 never hazards, nor does a non-writing producer
        drv(1, 0, 0, 0, 1, 1, 0); nxt();
        drv(1, 0, 0, 4, 1, 0, 0);
        expect_at(0, S_STALL, 0, "t3_x0_stall");
        expect_at(1, S_OP1,   0, "t3_x0_op1");
        expect_at(1, S_OP2,   0, "t3_x0_op2");
        nxt();
        drv(1, 0, 0, 12, 0, 0, 0); nxt();
        drv(1, 12, 0, 13, 1, 0, 0);
        expect_at(1, S_OP1, 0, "t3_nowe_op1");
        nxt();
        drain();

        // taken branch beats a load-use stall
        drv(1, 0, 0, 5, 1, 1, 0); nxt();
        drv(1, 5, 0, 6, 1, 0, 0);
        x_br_taken_i = 1'b1;
        expect_at(0, S_FLUSH, 1, "t4_flush");
        expect_at(0, S_STALL, 0, "t4_no_stall");
        expect_at(0, S_BUB,   1, "t4_bubble");
        expect_at(1, S_XV,    0, "t4_x_squashed");
        nxt();
        idle();
        x_br_taken_i = 1'b1;
        expect_at(0, S_FLUSH, 0, "t4_br_x_invalid");
        nxt();
        drain();

        // DIV: done arrives 10 cycles after start
        drv(1, 0, 0, 10, 1, 0, 1); nxt();
        drv(1, 10, 0, 11, 1, 0, 0);
        expect_at(0, S_START, 1, "t5_start");
        expect_at(0, S_STALL, 1, "t5_stall_start");
        expect_at(0, S_BUB,   0, "t5_bubble_start");
        expect_at(0, S_MV,    0, "t5_mv_start");
        nxt();
        for (int k = 2; k <= 10; k++) begin
            expect_at(0, S_STALL, 1, "t5_stall_wait");
            expect_at(0, S_START, 0, "t5_start_once");
            expect_at(0, S_MV,    0, "t5_mv_wait");
            expect_at(0, S_XV,    1, "t5_div_held");
            nxt();
        end
        mc_done_i = 1'b1;
        expect_at(0, S_STALL, 0, "t5_stall_done");
        expect_at(0, S_MV,    0, "t5_mv_done");
        expect_at(1, S_MV,    1, "t5_div_in_m");
        expect_at(1, S_OP1,   1, "t5_dep_op1");
        expect_at(1, S_START, 0, "t5_no_restart");
        nxt();
        idle();
        expect_at(1, S_WV,  1,  "t5_div_in_w");
        expect_at(1, S_WRD, 10, "t5_div_wrd");
        expect_at(1, S_ERR, 1,  "t5_err_sticky");
        nxt();
        drain();

        rst_i = 1'b1;
        expect_at(0, S_ERR, 0, "rst2_err");
        expect_at(0, S_WV,  0, "rst2_wv");
        nxt();
        rst_i = 1'b0;
        nxt();

        // MC timeout of 4, then async reset mid-wait
        drv(1, 0, 0, 11, 1, 0, 1); nxt();
        idle();
        expect_at(0, S_START, 1, "t6_start");
        nxt();
        for (int k = 1; k <= 3; k++) begin
            expect_at(0, S_ERR,   0, "t6_err_early");
            expect_at(0, S_STALL, 1, "t6_stall_wait");
            nxt();
        end
        expect_at(0, S_ERR, 1, "t6_err_at_4");
        nxt();
        rst_i = 1'b1;
        expect_at(0, S_ERR,   0, "t6_rst_err");
        expect_at(0, S_STALL, 0, "t6_rst_stall");
        expect_at(0, S_START, 0, "t6_rst_start");
        expect_at(0, S_XV,    0, "t6_rst_xv");
        nxt();
        rst_i = 1'b0;
        expect_at(0, S_START, 0, "t6_post_no_start");
        expect_at(0, S_STALL, 0, "t6_post_stall");
        nxt();
        drain();

        // FWD_EN=0 instance: stall until the producer leaves W
        drv(1, 0, 0, 3, 1, 0, 0); nxt();
        drv(1, 3, 0, 4, 1, 0, 0);
        expect_at(0, S_NF_STALL, 1, "t7_nf_stall_x");
        expect_at(0, S_NF_BUB,   1, "t7_nf_bubble");
        expect_at(0, S_STALL,    0, "t7_fwd_no_stall");
        nxt();
        expect_at(0, S_NF_STALL, 1, "t7_nf_stall_m");
        nxt();
        expect_at(0, S_NF_STALL, 1, "t7_nf_stall_w");
        nxt();
        expect_at(0, S_NF_STALL, 0, "t7_nf_released");
        expect_at(1, S_NF_OP1,   0, "t7_nf_op1");
        expect_at(1, S_NF_XV,    1, "t7_nf_xv");
        nxt();
        drain();
        drv(1, 0, 0, 0, 1, 0, 0); nxt();
        drv(1, 0, 0, 6, 1, 0, 0);
        expect_at(0, S_NF_STALL, 0, "t7_nf_x0");
        nxt();
        drain();

        check_val("sb_empty", 32'(due_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
